// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal register: hold/load/shift/rotate/clear plus a multi-cycle
// burst-rotate engine. Define USR_PARITY_EN to add the parity output and the parity_err load gate.
module univ_shift_reg #(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int             AW        = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  input  logic             start,
  input  logic             burst_dir,
  input  logic [AW-1:0]    amount,
`ifdef USR_PARITY_EN
  input  logic             parity_err,
  output logic             parity,
`endif
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_prev,
  output logic             ser_out_l,
  output logic             ser_out_r,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_LOAD  = 3'b001;
  localparam logic [2:0] M_SHL   = 3'b010;
  localparam logic [2:0] M_SHR   = 3'b011;
  localparam logic [2:0] M_ROL   = 3'b100;
  localparam logic [2:0] M_ROR   = 3'b101;
  localparam logic [2:0] M_CLEAR = 3'b110;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       r_state, w_state_next;
  logic [AW-1:0]    r_cnt, w_cnt_next;
  logic             r_dir, w_dir_next;
  logic [WIDTH-1:0] r_q, r_q_prev, w_q_next, w_op_q;
  logic [WIDTH-1:0] w_rol, w_ror;
  logic             w_rej;

  assign w_rol = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
  assign w_ror = {r_q[0], r_q[WIDTH-1:1]};

`ifdef USR_PARITY_EN
  assign w_rej = parity_err && (mode == M_LOAD);
`else
  assign w_rej = 1'b0;
`endif

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    w_op_q = r_q;
    case (mode)
      M_LOAD:  w_op_q = d;
      M_SHL:   w_op_q = {r_q[WIDTH-2:0], ser_in_r};
      M_SHR:   w_op_q = {ser_in_l, r_q[WIDTH-1:1]};
      M_ROL:   w_op_q = w_rol;
      M_ROR:   w_op_q = w_ror;
      M_CLEAR: w_op_q = '0;
      M_HOLD:  w_op_q = r_q;
      default: w_op_q = r_q;
    endcase
  end

  always_comb begin
    w_q_next     = r_q;
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_dir_next   = r_dir;
    case (r_state)
      S_IDLE: begin
        // start takes priority over any simultaneous mode operation
        if (start) begin
          if (amount != '0) begin
            w_cnt_next   = amount;
            w_dir_next   = burst_dir;
            w_state_next = S_SHIFT;
          end else begin
            w_state_next = S_DONE;
          end
        end else if (en) begin
          if (w_rej) w_state_next = S_DONE;
          else       w_q_next     = w_op_q;
        end
      end
      S_SHIFT: begin
        w_q_next   = r_dir ? w_ror : w_rol;
        w_cnt_next = r_cnt - AW'(1);
        if (r_cnt == AW'(1)) w_state_next = S_DONE;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_dir    <= 1'b0;
      r_q      <= RESET_VAL;
      r_q_prev <= RESET_VAL;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_dir   <= w_dir_next;
      r_q     <= w_q_next;
      if (w_q_next != r_q) r_q_prev <= r_q;
    end
  end

`ifdef USR_PARITY_EN
  logic r_parity;
  always_ff @(posedge clk) begin
    if (reset) r_parity <= ^RESET_VAL;
    else       r_parity <= ^w_q_next;
  end
  assign parity = r_parity;
`endif

  assign q         = r_q;
  assign q_prev    = r_q_prev;
  assign ser_out_l = r_q[WIDTH-1];
  assign ser_out_r = r_q[0];
  assign busy      = (r_state == S_SHIFT);
  assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg (WIDTH=8, RESET_VAL=A5): expected snapshots
// are queued as stimulus is driven and compared against post-edge DUT snapshots.
module tb_univ_shift_reg;

  localparam int         W  = 8;
  localparam logic [7:0] RV = 8'hA5;

  logic       clk = 1'b0;
  logic       reset, en, ser_in_l, ser_in_r, start, burst_dir;
  logic [2:0] mode;
  logic [7:0] d;
  logic [3:0] amount;
  logic [7:0] q, q_prev;
  logic       ser_out_l, ser_out_r, busy, done;

  univ_shift_reg #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d),
    .ser_in_l(ser_in_l), .ser_in_r(ser_in_r), .start(start),
    .burst_dir(burst_dir), .amount(amount),
    .q(q), .q_prev(q_prev), .ser_out_l(ser_out_l), .ser_out_r(ser_out_r),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] qp;
    logic       busy;
    logic       done;
  } snap_t;

  snap_t      exp_q[$];
  snap_t      obs_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] m_q, m_qp;

  function automatic logic [7:0] f_next(input logic [2:0] m, input logic [7:0] dd,
                                        input logic sl, input logic sr, input logic [7:0] c);
    case (m)
      3'd1:    return dd;
      3'd2:    return {c[6:0], sr};
      3'd3:    return {sl, c[7:1]};
      3'd4:    return {c[6:0], c[7]};
      3'd5:    return {c[0], c[7:1]};
      3'd6:    return 8'h00;
      default: return c;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    obs_q.push_back({q, q_prev, busy, done});
  endtask

  task automatic expect_now(input logic b, input logic dn);
    exp_q.push_back({m_q, m_qp, b, dn});
  endtask

  task automatic m_set(input logic [7:0] nq);
    if (nq !== m_q) m_qp = m_q;
    m_q = nq;
  endtask

  task automatic do_op(input logic e, input logic [2:0] m, input logic [7:0] dd,
                       input logic sl, input logic sr);
    en = e; mode = m; d = dd; ser_in_l = sl; ser_in_r = sr;
    tick();
    en = 1'b0;
    if (e) m_set(f_next(m, dd, sl, sr, m_q));
    expect_now(1'b0, 1'b0);
  endtask

  // Drives a burst; while the engine is busy/done, a conflicting start and LOAD are held asserted.
  task automatic do_burst(input int n, input logic dir, input logic with_load);
    start = 1'b1; amount = 4'(n); burst_dir = dir;
    if (with_load) begin en = 1'b1; mode = 3'd1; d = 8'hFF; end
    tick();
    expect_now(n != 0, n == 0);
    en = 1'b1; mode = 3'd1; d = 8'h55; start = 1'b1; amount = 4'd1;
    for (int k = 1; k <= n; k++) begin
      tick();
      m_set(dir ? {m_q[0], m_q[7:1]} : {m_q[6:0], m_q[7]});
      expect_now(k < n, k == n);
    end
    tick();
    expect_now(1'b0, 1'b0);
    en = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; m_q = RV; m_qp = RV;
    repeat (2) begin tick(); expect_now(1'b0, 1'b0); end
    reset = 1'b0;
    repeat (3) do_op(1'b1, 3'd0, 8'h3C, 1'b0, 1'b0);
    while (exp_q.size() != 0) begin
      snap_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset: got q=%h q_prev=%h busy=%b done=%b, want q=%h q_prev=%h busy=%b done=%b",
                 o.q, o.qp, o.busy, o.done, e.q, e.qp, e.busy, e.done);
      end
    end
  endtask

  task automatic test_load_shift();
    do_op(1'b1, 3'd1, 8'h81, 1'b0, 1'b0);
    do_op(1'b1, 3'd2, 8'h00, 1'b0, 1'b1);
    do_op(1'b1, 3'd3, 8'h00, 1'b1, 1'b0);
    do_op(1'b1, 3'd5, 8'h00, 1'b0, 1'b0);
    n_tests++;
    if (q !== 8'hC0 || ser_out_r !== 1'b0 || ser_out_l !== 1'b1) begin
      n_fail++;
      $display("FAIL ror_serial_outs: got q=%h sor=%b sol=%b, want q=c0 sor=0 sol=1", q, ser_out_r, ser_out_l);
    end
    do_op(1'b1, 3'd4, 8'h00, 1'b0, 1'b0);
    do_op(1'b1, 3'd2, 8'h00, 1'b0, 1'b0);
    do_op(1'b0, 3'd1, 8'h33, 1'b0, 1'b0);
    while (exp_q.size() != 0) begin
      snap_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL load_shift: got q=%h q_prev=%h busy=%b done=%b, want q=%h q_prev=%h busy=%b done=%b",
                 o.q, o.qp, o.busy, o.done, e.q, e.qp, e.busy, e.done);
      end
    end
  endtask

  task automatic test_burst();
    do_op(1'b1, 3'd1, 8'h01, 1'b0, 1'b0);
    do_burst(3, 1'b0, 1'b0);
    n_tests++;
    if (q !== 8'h08 || q_prev !== 8'h04) begin
      n_fail++;
      $display("FAIL burst3_final: got q=%h q_prev=%h, want q=08 q_prev=04", q, q_prev);
    end
    do_burst(5, 1'b1, 1'b0);
    while (exp_q.size() != 0) begin
      snap_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL burst: got q=%h q_prev=%h busy=%b done=%b, want q=%h q_prev=%h busy=%b done=%b",
                 o.q, o.qp, o.busy, o.done, e.q, e.qp, e.busy, e.done);
      end
    end
  endtask

  task automatic test_burst_edges();
    do_burst(0, 1'b0, 1'b0);
    do_op(1'b1, 3'd1, 8'h01, 1'b0, 1'b0);
    do_burst(9, 1'b0, 1'b0);
    n_tests++;
    if (q !== 8'h02) begin
      n_fail++;
      $display("FAIL burst9_final: got q=%h, want q=02", q);
    end
    do_burst(2, 1'b1, 1'b1);
    do_burst(8, 1'b0, 1'b1);
    while (exp_q.size() != 0) begin
      snap_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL burst_edges: got q=%h q_prev=%h busy=%b done=%b, want q=%h q_prev=%h busy=%b done=%b",
                 o.q, o.qp, o.busy, o.done, e.q, e.qp, e.busy, e.done);
      end
    end
  endtask

  task automatic test_abort();
    do_op(1'b1, 3'd1, 8'h01, 1'b0, 1'b0);
    start = 1'b1; amount = 4'd5; burst_dir = 1'b0;
    tick();
    start = 1'b0;
    expect_now(1'b1, 1'b0);
    tick();
    m_set({m_q[6:0], m_q[7]});
    expect_now(1'b1, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0; m_q = RV; m_qp = RV;
    expect_now(1'b0, 1'b0);
    repeat (4) begin tick(); expect_now(1'b0, 1'b0); end
    do_burst(1, 1'b0, 1'b0);
    while (exp_q.size() != 0) begin
      snap_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL abort: got q=%h q_prev=%h busy=%b done=%b, want q=%h q_prev=%h busy=%b done=%b",
                 o.q, o.qp, o.busy, o.done, e.q, e.qp, e.busy, e.done);
      end
    end
  endtask

  task automatic test_equal_load_reserved();
    do_op(1'b1, 3'd1, 8'h5A, 1'b0, 1'b0);
    do_op(1'b1, 3'd1, 8'h5A, 1'b0, 1'b0);
    do_op(1'b1, 3'd7, 8'hFF, 1'b1, 1'b1);
    do_op(1'b1, 3'd6, 8'hFF, 1'b0, 1'b0);
    n_tests++;
    if (q !== 8'h00 || q_prev !== 8'h5A) begin
      n_fail++;
      $display("FAIL clear: got q=%h q_prev=%h, want q=00 q_prev=5a", q, q_prev);
    end
    do_op(1'b1, 3'd6, 8'hFF, 1'b0, 1'b0);
    while (exp_q.size() != 0) begin
      snap_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL equal_load_reserved: got q=%h q_prev=%h busy=%b done=%b, want q=%h q_prev=%h busy=%b done=%b",
                 o.q, o.qp, o.busy, o.done, e.q, e.qp, e.busy, e.done);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0)
        do_burst(int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else
        do_op(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 8'($urandom),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    while (exp_q.size() != 0) begin
      snap_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL random: got q=%h q_prev=%h busy=%b done=%b, want q=%h q_prev=%h busy=%b done=%b",
                 o.q, o.qp, o.busy, o.done, e.q, e.qp, e.busy, e.done);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; en = 1'b0; mode = 3'd0; d = 8'h00; ser_in_l = 1'b0; ser_in_r = 1'b0;
    start = 1'b0; burst_dir = 1'b0; amount = 4'd0;
    test_reset();
    test_load_shift();
    test_burst();
    test_burst_edges();
    test_abort();
    test_equal_load_reserved();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
